// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stall/flush/forward controls out.
// The core side drives the master modport; the controller sits on the slave modport.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  i_RS1Valid_D;
    logic                  i_RS2Valid_D;
    logic [REG_ADDR_W-1:0] i_RS1Addr_D;
    logic [REG_ADDR_W-1:0] i_RS2Addr_D;
    logic [REG_ADDR_W-1:0] i_RS1Addr_E;
    logic [REG_ADDR_W-1:0] i_RS2Addr_E;
    logic [REG_ADDR_W-1:0] i_RDAddr_E;
    logic [REG_ADDR_W-1:0] i_RDAddr_M;
    logic [REG_ADDR_W-1:0] i_RDAddr_W;
    logic                  i_RegWr_E;
    logic                  i_RegWr_M;
    logic                  i_RegWr_W;
    logic                  i_IsMemRead_E;
    logic                  i_IsMemRead_M;
    logic                  i_IsMemRead_W;
    logic                  i_DBusGnt_M;
    logic                  i_DBusWaitReq_W;
    logic                  i_IsJump_M;
    logic                  i_IsBranch_M;
    logic                  i_TakeBranch_M;
    logic                  i_MulDivBusy_E;

    logic                  o_PcEn;
    logic                  o_IRamRdEn;
    logic                  o_IRamOZero;
    logic                  o_DBusTranslatorEn;
    logic                  o_RegEn_D;
    logic                  o_RegEn_E;
    logic                  o_RegEn_M;
    logic                  o_RegEn_W;
    logic                  o_RegClr_D;
    logic                  o_RegClr_E;
    logic                  o_RegClr_M;
    logic                  o_RegClr_W;
    logic [1:0]            o_FwdSelA_E;
    logic [1:0]            o_FwdSelB_E;
    logic                  o_FlushBusy;

    modport master (
        output i_RS1Valid_D, i_RS2Valid_D,
        output i_RS1Addr_D, i_RS2Addr_D,
        output i_RS1Addr_E, i_RS2Addr_E,
        output i_RDAddr_E, i_RDAddr_M, i_RDAddr_W,
        output i_RegWr_E, i_RegWr_M, i_RegWr_W,
        output i_IsMemRead_E, i_IsMemRead_M, i_IsMemRead_W,
        output i_DBusGnt_M, i_DBusWaitReq_W,
        output i_IsJump_M, i_IsBranch_M, i_TakeBranch_M,
        output i_MulDivBusy_E,
        input  o_PcEn, o_IRamRdEn, o_IRamOZero, o_DBusTranslatorEn,
        input  o_RegEn_D, o_RegEn_E, o_RegEn_M, o_RegEn_W,
        input  o_RegClr_D, o_RegClr_E, o_RegClr_M, o_RegClr_W,
        input  o_FwdSelA_E, o_FwdSelB_E, o_FlushBusy
    );

    modport slave (
        input  i_RS1Valid_D, i_RS2Valid_D,
        input  i_RS1Addr_D, i_RS2Addr_D,
        input  i_RS1Addr_E, i_RS2Addr_E,
        input  i_RDAddr_E, i_RDAddr_M, i_RDAddr_W,
        input  i_RegWr_E, i_RegWr_M, i_RegWr_W,
        input  i_IsMemRead_E, i_IsMemRead_M, i_IsMemRead_W,
        input  i_DBusGnt_M, i_DBusWaitReq_W,
        input  i_IsJump_M, i_IsBranch_M, i_TakeBranch_M,
        input  i_MulDivBusy_E,
        output o_PcEn, o_IRamRdEn, o_IRamOZero, o_DBusTranslatorEn,
        output o_RegEn_D, o_RegEn_E, o_RegEn_M, o_RegEn_W,
        output o_RegClr_D, o_RegClr_E, o_RegClr_M, o_RegClr_W,
        output o_FwdSelA_E, o_FwdSelB_E, o_FlushBusy
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W core: stalls, flushes, E-stage forwarding.
// The only state is the post-redirect bubble counter.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter bit MEM_FWD_EN   = 1'b1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES);

    logic [CW-1:0] r_FlushCnt;
    logic          waitStall;
    logic          redirect;
    logic          loadUse;
    logic          flushNz;
    logic          rs1Hit;
    logic          rs2Hit;

    function automatic logic match(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd,
        input logic                  wr
    );
        return wr && (rd == rs) && (rd != '0);
    endfunction

    function automatic logic ldHit(input logic [REG_ADDR_W-1:0] rs);
        logic hit;
        hit = match(rs, hz.i_RDAddr_E, hz.i_RegWr_E) && hz.i_IsMemRead_E;
        if (!MEM_FWD_EN) begin
            hit = hit
                | (match(rs, hz.i_RDAddr_M, hz.i_RegWr_M) && hz.i_IsMemRead_M)
                | (match(rs, hz.i_RDAddr_W, hz.i_RegWr_W) && hz.i_IsMemRead_W);
        end
        return hit;
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] rs);
        if (match(rs, hz.i_RDAddr_M, hz.i_RegWr_M) && !hz.i_IsMemRead_M)
            return 2'd1;
        else if (match(rs, hz.i_RDAddr_W, hz.i_RegWr_W)
                 && (MEM_FWD_EN || !hz.i_IsMemRead_W))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign waitStall = hz.i_DBusWaitReq_W && hz.i_DBusGnt_M;
    assign redirect  = (hz.i_IsBranch_M && hz.i_TakeBranch_M) || hz.i_IsJump_M;
    assign rs1Hit    = hz.i_RS1Valid_D && ldHit(hz.i_RS1Addr_D);
    assign rs2Hit    = hz.i_RS2Valid_D && ldHit(hz.i_RS2Addr_D);
    assign loadUse   = rs1Hit || rs2Hit;
    assign flushNz   = (r_FlushCnt != '0);

    always_comb begin
        hz.o_PcEn             = 1'b1;
        hz.o_IRamRdEn         = 1'b1;
        hz.o_IRamOZero        = 1'b0;
        hz.o_DBusTranslatorEn = 1'b1;
        hz.o_RegEn_D          = 1'b1;
        hz.o_RegEn_E          = 1'b1;
        hz.o_RegEn_M          = 1'b1;
        hz.o_RegEn_W          = 1'b1;
        hz.o_RegClr_D         = 1'b0;
        hz.o_RegClr_E         = 1'b0;
        hz.o_RegClr_M         = 1'b0;
        hz.o_RegClr_W         = 1'b0;
        hz.o_FwdSelA_E        = fwdSel(hz.i_RS1Addr_E);
        hz.o_FwdSelB_E        = fwdSel(hz.i_RS2Addr_E);
        hz.o_FlushBusy        = flushNz && !i_Rst;
        if (i_Rst) begin
            hz.o_RegClr_D  = 1'b1;
            hz.o_RegClr_E  = 1'b1;
            hz.o_RegClr_M  = 1'b1;
            hz.o_RegClr_W  = 1'b1;
            hz.o_FwdSelA_E = 2'd0;
            hz.o_FwdSelB_E = 2'd0;
        end else if (waitStall) begin
            hz.o_PcEn             = 1'b0;
            hz.o_IRamRdEn         = 1'b0;
            hz.o_DBusTranslatorEn = 1'b0;
            hz.o_RegEn_D          = 1'b0;
            hz.o_RegEn_E          = 1'b0;
            hz.o_RegEn_M          = 1'b0;
            hz.o_RegEn_W          = 1'b0;
        end else begin
            if (redirect) begin
                hz.o_RegClr_D = 1'b1;
                hz.o_RegClr_E = 1'b1;
                hz.o_RegClr_M = 1'b1;
            end else if (hz.i_MulDivBusy_E) begin
                hz.o_PcEn     = 1'b0;
                hz.o_IRamRdEn = 1'b0;
                hz.o_RegEn_D  = 1'b0;
                hz.o_RegEn_E  = 1'b0;
                hz.o_RegClr_M = 1'b1;
            end else if (loadUse) begin
                hz.o_PcEn     = 1'b0;
                hz.o_IRamRdEn = 1'b0;
                hz.o_RegEn_D  = 1'b0;
                hz.o_RegClr_E = 1'b1;
            end
            // Redirect bubbles: hold E empty, and hold D until the last bubble
            if (flushNz) begin
                hz.o_RegEn_E   = 1'b0;
                hz.o_IRamOZero = 1'b1;
                if (r_FlushCnt > CW'(1))
                    hz.o_RegEn_D = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            r_FlushCnt <= '0;
        else if (waitStall)
            r_FlushCnt <= r_FlushCnt;
        else if (redirect)
            r_FlushCnt <= CNT_INIT;
        else if (flushNz)
            r_FlushCnt <= r_FlushCnt - CW'(1);
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue-based scoreboard.
// Expected control words are hand-computed for FLUSH_CYCLES=2, MEM_FWD_EN=1.
module tb_pipeline_hazard_ctrl;
    logic i_Clk = 1'b0;
    logic i_Rst;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .FLUSH_CYCLES(2),
        .MEM_FWD_EN  (1'b1)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .hz   (hz)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        string       name;
        logic [16:0] exp;
    } expT;

    expT q[$];
    int  checks = 0;
    int  errors = 0;

    // {pc,iram,ozero,dbus,en[D,E,M,W],clr[D,E,M,W],fwdA,fwdB,busy}
    function automatic logic [16:0] mk(
        input logic       pc,
        input logic       iram,
        input logic       oz,
        input logic       dbus,
        input logic [3:0] en,
        input logic [3:0] clr,
        input logic [1:0] fa,
        input logic [1:0] fb,
        input logic       busy
    );
        return {pc, iram, oz, dbus, en, clr, fa, fb, busy};
    endfunction

    logic [16:0] act;
    assign act = {hz.o_PcEn, hz.o_IRamRdEn, hz.o_IRamOZero,
                  hz.o_DBusTranslatorEn,
                  hz.o_RegEn_D, hz.o_RegEn_E, hz.o_RegEn_M, hz.o_RegEn_W,
                  hz.o_RegClr_D, hz.o_RegClr_E, hz.o_RegClr_M, hz.o_RegClr_W,
                  hz.o_FwdSelA_E, hz.o_FwdSelB_E, hz.o_FlushBusy};

    always @(negedge i_Clk) begin
        if (q.size() > 0) begin
            expT e;
            e = q.pop_front();
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s got %b exp %b", e.name, act, e.exp);
            end
        end
    end

    task automatic clearIn();
        hz.i_RS1Valid_D    = 1'b0;
        hz.i_RS2Valid_D    = 1'b0;
        hz.i_RS1Addr_D     = '0;
        hz.i_RS2Addr_D     = '0;
        hz.i_RS1Addr_E     = '0;
        hz.i_RS2Addr_E     = '0;
        hz.i_RDAddr_E      = '0;
        hz.i_RDAddr_M      = '0;
        hz.i_RDAddr_W      = '0;
        hz.i_RegWr_E       = 1'b0;
        hz.i_RegWr_M       = 1'b0;
        hz.i_RegWr_W       = 1'b0;
        hz.i_IsMemRead_E   = 1'b0;
        hz.i_IsMemRead_M   = 1'b0;
        hz.i_IsMemRead_W   = 1'b0;
        hz.i_DBusGnt_M     = 1'b0;
        hz.i_DBusWaitReq_W = 1'b0;
        hz.i_IsJump_M      = 1'b0;
        hz.i_IsBranch_M    = 1'b0;
        hz.i_TakeBranch_M  = 1'b0;
        hz.i_MulDivBusy_E  = 1'b0;
    endtask

    // Inputs are already set; queue the expectation and advance one cycle
    task automatic step(input string name, input logic [16:0] e);
        expT t;
        t.name = name;
        t.exp  = e;
        q.push_back(t);
        @(posedge i_Clk);
        #1;
    endtask

    task automatic loadUseE5();
        hz.i_RS1Valid_D  = 1'b1;
        hz.i_RS1Addr_D   = 5'd5;
        hz.i_RDAddr_E    = 5'd5;
        hz.i_RegWr_E     = 1'b1;
        hz.i_IsMemRead_E = 1'b1;
    endtask

    logic [16:0] dflt, rstV, brClr, fl2, fl1, wait2, mdStall, luStall;

    initial begin
        dflt    = mk(1, 1, 0, 1, 4'b1111, 4'b0000, 2'd0, 2'd0, 0);
        rstV    = mk(1, 1, 0, 1, 4'b1111, 4'b1111, 2'd0, 2'd0, 0);
        brClr   = mk(1, 1, 0, 1, 4'b1111, 4'b1110, 2'd0, 2'd0, 0);
        fl2     = mk(1, 1, 1, 1, 4'b0011, 4'b0000, 2'd0, 2'd0, 1);
        fl1     = mk(1, 1, 1, 1, 4'b1011, 4'b0000, 2'd0, 2'd0, 1);
        wait2   = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 2'd0, 1);
        mdStall = mk(0, 0, 0, 1, 4'b0011, 4'b0010, 2'd0, 2'd0, 0);
        luStall = mk(0, 0, 0, 1, 4'b0111, 4'b0100, 2'd0, 2'd0, 0);

        clearIn();
        i_Rst = 1'b1;
        @(posedge i_Clk);
        #1;
        step("reset0", rstV);
        step("reset1", rstV);
        i_Rst = 1'b0;
        step("idle", dflt);

        loadUseE5();
        step("loaduse_x5", luStall);
        clearIn();
        hz.i_RDAddr_W = 5'd5; hz.i_RegWr_W = 1'b1; hz.i_IsMemRead_W = 1'b1;
        hz.i_RS1Addr_E = 5'd5; hz.i_RS2Addr_E = 5'd5;
        step("fwd_load_w", mk(1, 1, 0, 1, 4'b1111, 4'b0000, 2'd2, 2'd2, 0));

        clearIn();
        hz.i_RS1Valid_D = 1'b1; hz.i_RDAddr_E = 5'd0;
        hz.i_RegWr_E = 1'b1; hz.i_IsMemRead_E = 1'b1;
        hz.i_RegWr_M = 1'b1; hz.i_RDAddr_M = 5'd3; hz.i_RS1Addr_E = 5'd3;
        step("x0_nostall_fwdM", mk(1, 1, 0, 1, 4'b1111, 4'b0000, 2'd1, 2'd0, 0));

        clearIn();
        hz.i_RS1Addr_E = 5'd7; hz.i_RS2Addr_E = 5'd7;
        hz.i_RDAddr_M = 5'd7; hz.i_RegWr_M = 1'b1;
        hz.i_RDAddr_W = 5'd7; hz.i_RegWr_W = 1'b1;
        step("fwd_m_over_w", mk(1, 1, 0, 1, 4'b1111, 4'b0000, 2'd1, 2'd1, 0));
        hz.i_IsMemRead_M = 1'b1; hz.i_RS2Addr_E = 5'd0; hz.i_RDAddr_W = 5'd7;
        step("fwd_loadM_to_w", mk(1, 1, 0, 1, 4'b1111, 4'b0000, 2'd2, 2'd0, 0));

        clearIn();
        hz.i_IsBranch_M = 1'b1; hz.i_TakeBranch_M = 1'b1;
        step("branch_taken", brClr);
        clearIn();
        step("flush_cnt2", fl2);
        step("flush_cnt1", fl1);
        step("flush_done", dflt);
        hz.i_IsBranch_M = 1'b1;
        step("branch_not_taken", dflt);

        clearIn();
        hz.i_IsJump_M = 1'b1;
        step("jump", brClr);
        clearIn();
        hz.i_DBusWaitReq_W = 1'b1; hz.i_DBusGnt_M = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("waitreq%0d", i), wait2);
        clearIn();
        step("resume_cnt2", fl2);
        step("resume_cnt1", fl1);
        hz.i_DBusWaitReq_W = 1'b1;
        step("waitreq_no_gnt", dflt);

        clearIn();
        loadUseE5();
        hz.i_MulDivBusy_E = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("muldiv%0d", i), mdStall);

        clearIn();
        hz.i_IsJump_M = 1'b1;
        step("jump2", brClr);
        clearIn();
        hz.i_MulDivBusy_E = 1'b1;
        step("muldiv_flush2", mk(0, 0, 1, 1, 4'b0011, 4'b0010, 2'd0, 2'd0, 1));
        clearIn();
        loadUseE5();
        step("loaduse_flush1", mk(0, 0, 1, 1, 4'b0011, 4'b0100, 2'd0, 2'd0, 1));

        clearIn();
        hz.i_IsJump_M = 1'b1;
        step("jump3", brClr);
        clearIn();
        step("flush_before_rst", fl2);
        i_Rst = 1'b1;
        step("rst_mid_flush", rstV);
        i_Rst = 1'b0;
        step("after_rst", dflt);

        hz.i_RS2Valid_D = 1'b1; hz.i_RS2Addr_D = 5'd9;
        hz.i_RDAddr_M = 5'd9; hz.i_RegWr_M = 1'b1; hz.i_IsMemRead_M = 1'b1;
        step("loadM_no_stall", dflt);
        clearIn();
        hz.i_RS2Addr_D = 5'd9; hz.i_RDAddr_E = 5'd9;
        hz.i_RegWr_E = 1'b1; hz.i_IsMemRead_E = 1'b1;
        step("rs2_invalid", dflt);
        hz.i_RS2Valid_D = 1'b1;
        step("rs2_loaduse", luStall);

        clearIn();
        hz.i_IsJump_M = 1'b1; hz.i_MulDivBusy_E = 1'b1;
        step("jump_over_muldiv", brClr);
        clearIn();
        step("drain2", fl2);
        step("drain1", fl1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge i_Clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
